// File: rtl/ippcrc_crc32_sched.sv
// ippcrc_crc32_sched: round-robin scheduler sharing one 120-bit CRC-32 step.
// Optional IPPCRC_SCHED_RESIDUE_CHK_EN adds crc_err (remainder != RESIDUE).
module ippcrc_crc32_sched #(
  parameter int          NCH        = 4,
  parameter int          CHW        = 2,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
  ,
  parameter logic [31:0] RESIDUE    = 32'hC704DD7B
`endif
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [NCH-1:0]     req_vld,
  output logic [NCH-1:0]     req_rdy,
  input  logic [NCH-1:0]     req_sop,
  input  logic [NCH-1:0]     req_eop,
  input  logic [NCH*4-1:0]   req_nbyte,
  input  logic [NCH*120-1:0] req_data,
  output logic               crc_vld,
  output logic [CHW-1:0]     crc_ch,
  output logic [31:0]        crc_val
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
  ,
  output logic               crc_err
`endif
);

  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef enum logic {S_IDLE, S_TAIL} state_t;

  // Context register is MSB-first; data enters bit 0 first.
  function automatic logic [31:0] f_bit(
    input logic [31:0] c,
    input logic        d
  );
    return {c[30:0], 1'b0} ^ ((c[31] ^ d) ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] f_step120(
    input logic [31:0]  ci,
    input logic [119:0] d
  );
    logic [31:0] c;
    c = ci;
    for (int i = 0; i < 120; i++) c = f_bit(c, d[i]);
    return c;
  endfunction

  function automatic logic [31:0] f_step8(
    input logic [31:0] ci,
    input logic [7:0]  d
  );
    logic [31:0] c;
    c = ci;
    for (int i = 0; i < 8; i++) c = f_bit(c, d[i]);
    return c;
  endfunction

  state_t         r_state;
  state_t         w_nstate;
  logic [31:0]    r_ctx [NCH];
  logic [CHW-1:0] r_ptr;
  logic [119:0]   r_tdat;
  logic [CHW-1:0] r_tch;
  logic [3:0]     r_tcnt;
  logic [31:0]    r_tcrc;

  logic [119:0]   w_dat [NCH];
  logic [3:0]     w_nbs [NCH];
  logic [NCH-1:0] w_gnt;
  logic [CHW-1:0] w_gch;
  logic [CHW-1:0] w_pnxt;
  logic           w_hit;
  logic           w_xfer;
  logic           w_sop;
  logic           w_eop;
  logic [3:0]     w_nb;
  logic           w_full;
  logic [31:0]    w_ci;
  logic [31:0]    w_step;
  logic [31:0]    w_tstep;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_dat[gi] = req_data[120*gi +: 120];
    assign w_nbs[gi] = req_nbyte[4*gi +: 4];
  end

  always_comb begin
    logic [CHW:0] w_s;
    w_gnt = '0;
    w_gch = '0;
    w_hit = 1'b0;
    w_s   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_s = {1'b0, r_ptr} + (CHW+1)'(k);
      if (w_s >= (CHW+1)'(NCH)) w_s = w_s - (CHW+1)'(NCH);
      if (!w_hit && req_vld[w_s[CHW-1:0]]) begin
        w_hit = 1'b1;
        w_gch = w_s[CHW-1:0];
      end
    end
    if (w_hit) w_gnt[w_gch] = 1'b1;
  end

  assign req_rdy = (rst_ && r_state == S_IDLE) ? w_gnt : '0;
  assign w_xfer  = |req_rdy;
  assign w_sop   = req_sop[w_gch];
  assign w_eop   = req_eop[w_gch];
  assign w_nb    = w_nbs[w_gch];
  assign w_full  = (w_nb == 4'd0) || (w_nb == 4'd15);
  assign w_ci    = w_sop ? CRC_INIT : r_ctx[w_gch];
  assign w_step  = f_step120(w_ci, w_dat[w_gch]);
  assign w_tstep = f_step8(r_tcrc, r_tdat[7:0]);
  assign w_pnxt  = (w_gch == CHW'(NCH-1)) ? '0 : w_gch + CHW'(1);

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE: if (w_xfer && w_eop && !w_full) w_nstate = S_TAIL;
      S_TAIL: if (r_tcnt == 4'd0) w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      for (int i = 0; i < NCH; i++) r_ctx[i] <= CRC_INIT;
      r_ptr   <= '0;
      r_tdat  <= '0;
      r_tch   <= '0;
      r_tcnt  <= '0;
      r_tcrc  <= '0;
      crc_vld <= 1'b0;
      crc_ch  <= '0;
      crc_val <= '0;
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
      crc_err <= 1'b0;
`endif
    end else begin
      crc_vld <= 1'b0;
      if (w_xfer) begin
        r_ptr <= w_pnxt;
        if (!w_eop) begin
          r_ctx[w_gch] <= w_step;
        end else if (w_full) begin
          r_ctx[w_gch] <= CRC_INIT;
          crc_vld      <= 1'b1;
          crc_ch       <= w_gch;
          crc_val      <= w_step ^ CRC_XOROUT;
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
          crc_err      <= (w_step != RESIDUE);
`endif
        end else begin
          r_tdat <= w_dat[w_gch];
          r_tch  <= w_gch;
          r_tcnt <= w_nb - 4'd1;
          r_tcrc <= w_ci;
        end
      end
      if (r_state == S_TAIL) begin
        r_tdat <= {8'h00, r_tdat[119:8]};
        r_tcrc <= w_tstep;
        r_tcnt <= r_tcnt - 4'd1;
        if (r_tcnt == 4'd0) begin
          r_ctx[r_tch] <= CRC_INIT;
          crc_vld      <= 1'b1;
          crc_ch       <= r_tch;
          crc_val      <= w_tstep ^ CRC_XOROUT;
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
          crc_err      <= (w_tstep != RESIDUE);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ippcrc_crc32_sched.sv
// tb_ippcrc_crc32_sched: vector table, directed corner cases and random
// traffic checked against a per-channel byte-list CRC reference.
module tb_ippcrc_crc32_sched;

  localparam int          NCH  = 4;
  localparam int          CHW  = 2;
  localparam logic [31:0] XOR  = 32'hFFFFFFFF;
  localparam logic [31:0] RES  = 32'hC704DD7B;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [119:0] data;
    bit           sop;
    bit           eop;
    logic [3:0]   nb;
  } word_t;
  typedef struct {
    int          due;
    int          ch;
    logic [31:0] val;
    bit          err;
  } exp_t;
  typedef struct {
    int           ch;
    logic [119:0] data;
    logic [3:0]   nb;
    logic [31:0]  exp;
  } vec_t;

  logic               clk;
  logic               rst_;
  logic [NCH-1:0]     req_vld;
  logic [NCH-1:0]     req_rdy;
  logic [NCH-1:0]     req_sop;
  logic [NCH-1:0]     req_eop;
  logic [NCH*4-1:0]   req_nbyte;
  logic [NCH*120-1:0] req_data;
  logic               crc_vld;
  logic [CHW-1:0]     crc_ch;
  logic [31:0]        crc_val;
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
  logic               crc_err;
  bit                 last_err;
`endif

  ippcrc_crc32_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_sop   (req_sop),
    .req_eop   (req_eop),
    .req_nbyte (req_nbyte),
    .req_data  (req_data),
    .crc_vld   (crc_vld),
    .crc_ch    (crc_ch),
    .crc_val   (crc_val)
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
    ,
    .crc_err   (crc_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          nres  = 0;
  int          ptr_m = 0;
  int          tail_m = 0;
  int          acc_cyc = 0;
  int          last_cyc = 0;
  int          last_ch = 0;
  logic [31:0] last_val = '0;
  logic [31:0] res_by_ch [NCH];
  bit          rst_req = 1'b0;
  word_t       wq [NCH][$];
  bq_t         pk [NCH];
  bq_t         tq;
  exp_t        sq [$];
  int          glog [$];
  int          gcyc [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference CRC over a whole byte list, bit 0 of each byte first.
  function automatic logic [31:0] crc_rem(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int j = 0; j < 8; j++) begin
        bit fb;
        fb = c[31] ^ q[i][j];
        c  = c << 1;
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  function automatic logic [119:0] rnd120();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[119:0];
  endfunction

  task automatic tq_add(input logic [119:0] d, input int n);
    for (int b = 0; b < n; b++) tq.push_back(d[8*b +: 8]);
  endtask

  task automatic push(input int c, input logic [119:0] d, input bit s,
                      input bit e, input logic [3:0] nb);
    word_t w;
    w.data = d;
    w.sop  = s;
    w.eop  = e;
    w.nb   = nb;
    wq[c].push_back(w);
  endtask

  task automatic step();
    logic [NCH-1:0] er;
    logic [31:0]    rem;
    word_t          w;
    int             g;
    int             n;
    exp_t           x;
    @(negedge clk);
    cyc++;
    rst_ = rst_req;
    if (sq.size() > 0 && sq[0].due == cyc) begin
      chk("vld", crc_vld, 1);
      chk("ch", crc_ch, sq[0].ch);
      chk("val", crc_val, sq[0].val);
`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
      chk("err", crc_err, sq[0].err);
      last_err = crc_err;
`endif
      last_val = crc_val;
      last_ch  = crc_ch;
      last_cyc = cyc;
      res_by_ch[crc_ch] = crc_val;
      nres++;
      void'(sq.pop_front());
    end else begin
      chk("novld", crc_vld, 0);
    end
    for (int c = 0; c < NCH; c++) begin
      if (wq[c].size() > 0) begin
        req_vld[c] = 1'b1;
        req_sop[c] = wq[c][0].sop;
        req_eop[c] = wq[c][0].eop;
        req_nbyte[4*c +: 4] = wq[c][0].nb;
        req_data[120*c +: 120] = wq[c][0].data;
      end else begin
        req_vld[c] = 1'b0;
        req_sop[c] = 1'b0;
        req_eop[c] = 1'b0;
      end
    end
    #1;
    er = '0;
    g  = -1;
    if (rst_ && tail_m == 0) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (ptr_m + k) % NCH;
        if (g < 0 && req_vld[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("rdy", req_rdy, er);
    if (!rst_) begin
      for (int c = 0; c < NCH; c++) pk[c].delete();
      ptr_m  = 0;
      tail_m = 0;
      sq.delete();
    end else if (tail_m > 0) begin
      tail_m--;
    end else if (g >= 0) begin
      w = wq[g].pop_front();
      glog.push_back(g);
      gcyc.push_back(cyc);
      if (w.sop) pk[g].delete();
      n = (!w.eop || w.nb == 4'd0) ? 15 : int'(w.nb);
      for (int b = 0; b < n; b++) pk[g].push_back(w.data[8*b +: 8]);
      ptr_m = (g + 1) % NCH;
      if (w.eop) begin
        rem = crc_rem(pk[g]);
        pk[g].delete();
        x.due = cyc + ((n == 15) ? 1 : n + 1);
        x.ch  = g;
        x.val = rem ^ XOR;
        x.err = (rem != RES);
        sq.push_back(x);
        acc_cyc = cyc;
        tail_m  = (n == 15) ? 0 : n;
      end
    end
  endtask

  task automatic run_res(input string nm, input int cnt, input int lim);
    int n0;
    int k;
    n0 = nres;
    k  = 0;
    while (nres < n0 + cnt && k < lim) begin
      step();
      k++;
    end
    chk(nm, nres - n0, cnt);
  endtask

  task automatic do_reset();
    rst_req = 1'b0;
    step();
    step();
    rst_req = 1'b1;
  endtask

  initial begin
    vec_t         tbl [5];
    logic [119:0] d;
    logic [119:0] d2;
    logic [31:0]  v;
    string        s;
    int           k;
    int           lat;

    rst_ = 1'b0;
    req_vld = '0;
    req_sop = '0;
    req_eop = '0;
    req_nbyte = '0;
    req_data = '0;
    for (int c = 0; c < NCH; c++) res_by_ch[c] = '0;

    s = "123456789";
    d = '0;
    for (int b = 0; b < 9; b++) d[8*b +: 8] = s[b];
    tbl[0] = '{0, 120'h0, 4'd15, 32'h0};
    tbl[1] = '{2, d, 4'd9, 32'h649C2FD3};
    tbl[2] = '{1, rnd120(), 4'd0, 32'h0};
    tbl[3] = '{3, rnd120(), 4'd1, 32'h0};
    tbl[4] = '{3, rnd120(), 4'd14, 32'h0};
    foreach (tbl[i]) begin
      if (i != 1) begin
        tq.delete();
        tq_add(tbl[i].data, (tbl[i].nb == 4'd0) ? 15 : int'(tbl[i].nb));
        tbl[i].exp = crc_rem(tq) ^ XOR;
      end
    end

    rst_req = 1'b0;
    repeat (3) step();
    chk("rst_vld", crc_vld, 0);
    chk("rst_ch", crc_ch, 0);
    chk("rst_val", crc_val, 0);
    chk("rst_rdy", req_rdy, 0);
    rst_req = 1'b1;

    for (int i = 0; i < 5; i++) begin
      push(tbl[i].ch, tbl[i].data, 1'b1, 1'b1, tbl[i].nb);
      run_res("tbl_done", 1, 40);
      lat = (tbl[i].nb == 4'd0 || tbl[i].nb == 4'd15) ? 1
            : int'(tbl[i].nb) + 1;
      chk("tbl_val", last_val, tbl[i].exp);
      chk("tbl_ch", last_ch, tbl[i].ch);
      chk("tbl_lat", last_cyc - acc_cyc, lat);
    end

    do_reset();
    glog.delete();
    gcyc.delete();
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < NCH; c++) begin
        push(c, rnd120(), w == 0, w == 2, 4'd15);
      end
    end
    run_res("rr_done", 4, 60);
    chk("rr_n", glog.size(), 12);
    for (int i = 0; i < glog.size() && i < 12; i++) begin
      chk("rr_ord", glog[i], i % NCH);
      chk("rr_gap", gcyc[i] - gcyc[0], i);
    end

    d  = rnd120();
    d2 = rnd120();
    tq.delete();
    tq_add(d2, 15);
    push(1, rnd120(), 1'b1, 1'b0, 4'd15);
    push(1, d2, 1'b1, 1'b0, 4'd15);
    push(1, d, 1'b0, 1'b1, 4'd5);
    tq_add(d, 5);
    run_res("rs_done", 1, 40);
    chk("restart", last_val, crc_rem(tq) ^ XOR);
    chk("restart_ch", last_ch, 1);

    push(1, rnd120(), 1'b1, 1'b0, 4'd15);
    k = 0;
    while (wq[1].size() > 0 && k < 20) begin
      step();
      k++;
    end
    push(2, rnd120(), 1'b1, 1'b1, 4'd12);
    k = 0;
    while (tail_m == 0 && k < 20) begin
      step();
      k++;
    end
    chk("tail_seen", tail_m, 12);
    repeat (5) step();
    rst_req = 1'b0;
    step();
    rst_req = 1'b1;
    repeat (15) step();
    glog.delete();
    d = rnd120();
    push(3, rnd120(), 1'b1, 1'b1, 4'd15);
    push(1, d, 1'b0, 1'b1, 4'd15);
    push(0, rnd120(), 1'b1, 1'b1, 4'd15);
    run_res("post_rst", 3, 30);
    chk("ptr0", (glog.size() > 0) ? glog[0] : -1, 0);
    tq.delete();
    tq_add(d, 15);
    chk("ctx_init", res_by_ch[1], crc_rem(tq) ^ XOR);

`ifdef IPPCRC_SCHED_RESIDUE_CHK_EN
    for (int f = 0; f < 2; f++) begin
      d  = rnd120();
      d2 = rnd120();
      tq.delete();
      tq_add(d, 15);
      tq_add(d2, 5);
      v = crc_rem(tq) ^ XOR;
      for (int i = 0; i < 32; i++) d2[40+i] = v[31-i];
      if (f == 1) d[17] = ~d[17];
      push(0, d, 1'b1, 1'b0, 4'd15);
      push(0, d2, 1'b0, 1'b1, 4'd9);
      run_res("res_done", 1, 40);
      chk("res_err", last_err, f);
    end
`endif

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (wq[c].size() == 0 && $urandom_range(0, 3) == 0) begin
          int nw;
          nw = $urandom_range(1, 3);
          for (int w = 0; w < nw; w++) begin
            push(c, rnd120(),
                 (w == 0) && ($urandom_range(0, 7) != 0),
                 w == nw - 1, 4'($urandom_range(0, 15)));
          end
        end
      end
      step();
    end
    k = 0;
    while ((sq.size() > 0 || wq[0].size() > 0 || wq[1].size() > 0 ||
            wq[2].size() > 0 || wq[3].size() > 0) && k < 600) begin
      step();
      k++;
    end
    chk("drain", sq.size(), 0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
